// File: rtl/aes_round_ctrl_if.sv
// Handshake and round-status bundle between the host front end and the AES
// round sequencer.
//   master : host side. Drives start_valid, key_len, decrypt and abort, and
//            observes the round outputs.
//   slave  : sequencer side. Observes the request and drives start_ready,
//            rnd_no, enb_ks, rnd_active, last_rnd, rnd_onehot and done.
interface aes_round_ctrl_if;
  logic        start_valid;
  logic        start_ready;
  logic [1:0]  key_len;
  logic        decrypt;
  logic        abort;
  logic [3:0]  rnd_no;
  logic        enb_ks;
  logic        rnd_active;
  logic        last_rnd;
  logic [13:0] rnd_onehot;
  logic        done;

  modport master (
    output start_valid, key_len, decrypt, abort,
    input  start_ready, rnd_no, enb_ks, rnd_active, last_rnd, rnd_onehot, done
  );

  modport slave (
    input  start_valid, key_len, decrypt, abort,
    output start_ready, rnd_no, enb_ks, rnd_active, last_rnd, rnd_onehot, done
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES datapath. It accepts one block per
// start handshake and runs 10/12/14 rounds of CYC_PER_RND cycles each,
// depending on the key length. Round numbers are issued in encrypt or
// decrypt order.
// Ports:
//   clk   rising-edge clock
//   rstn  synchronous active-low reset
//   bus   aes_round_ctrl_if.slave. Inputs: start_valid, key_len, decrypt,
//         abort. Outputs: start_ready, rnd_no, enb_ks, rnd_active,
//         last_rnd, rnd_onehot, done.
//
// state | meaning
// IDLE  | waiting for a block; start_ready high
// RUN   | stepping through rounds; p = progress round, ph = phase in round
module aes_round_ctrl #(
  parameter int CYC_PER_RND = 4,
  parameter bit DEC_EN      = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  aes_round_ctrl_if.slave  bus
);

  localparam int PH_W = $clog2(CYC_PER_RND);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CYC_PER_RND - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  p_q, p_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [3:0]  nr_q, nr_d;
  logic        dir_q, dir_d;

  logic        start_ready_q, start_ready_d;
  logic [3:0]  rnd_no_q, rnd_no_d;
  logic        enb_ks_q, enb_ks_d;
  logic        rnd_active_q, rnd_active_d;
  logic        last_rnd_q, last_rnd_d;
  logic [13:0] rnd_onehot_q, rnd_onehot_d;
  logic        done_q, done_d;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    ph_d    = ph_q;
    nr_d    = nr_q;
    dir_d   = dir_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // abort is a don't-care here; a concurrent start is still taken
        if (bus.start_valid) begin
          case (bus.key_len)
            2'b01:   nr_d = 4'd12;
            2'b10:   nr_d = 4'd14;
            default: nr_d = 4'd10;
          endcase
          dir_d   = bus.decrypt & DEC_EN;
          p_d     = 4'd1;
          ph_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // abort wins over completion, so no done pulse on an aborted block
        if (bus.abort) begin
          state_d = IDLE;
          p_d     = 4'd0;
          ph_d    = '0;
        end else if (ph_q == PH_LAST) begin
          ph_d = '0;
          if (p_q == nr_q) begin
            state_d = IDLE;
            p_d     = 4'd0;
            done_d  = 1'b1;
          end else begin
            p_d = p_q + 4'd1;
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        p_d     = 4'd0;
        ph_d    = '0;
      end
    endcase

    // Outputs are registered, so they are derived from the next-state values
    // and line up with the state they describe.
    rnd_active_d  = (state_d == RUN);
    start_ready_d = ~rnd_active_d;
    enb_ks_d      = rnd_active_d && (ph_d == '0);
    last_rnd_d    = rnd_active_d && (p_d == nr_d);
    rnd_no_d      = 4'd0;
    rnd_onehot_d  = 14'd0;
    if (rnd_active_d) begin
      rnd_no_d     = dir_d ? (nr_d - p_d) : p_d;
      rnd_onehot_d = 14'd1 << (p_d - 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      p_q           <= 4'd0;
      ph_q          <= '0;
      nr_q          <= 4'd10;
      dir_q         <= 1'b0;
      start_ready_q <= 1'b1;
      rnd_no_q      <= 4'd0;
      enb_ks_q      <= 1'b0;
      rnd_active_q  <= 1'b0;
      last_rnd_q    <= 1'b0;
      rnd_onehot_q  <= 14'd0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      p_q           <= p_d;
      ph_q          <= ph_d;
      nr_q          <= nr_d;
      dir_q         <= dir_d;
      start_ready_q <= start_ready_d;
      rnd_no_q      <= rnd_no_d;
      enb_ks_q      <= enb_ks_d;
      rnd_active_q  <= rnd_active_d;
      last_rnd_q    <= last_rnd_d;
      rnd_onehot_q  <= rnd_onehot_d;
      done_q        <= done_d;
    end
  end

  assign bus.start_ready = start_ready_q;
  assign bus.rnd_no      = rnd_no_q;
  assign bus.enb_ks      = enb_ks_q;
  assign bus.rnd_active  = rnd_active_q;
  assign bus.last_rnd    = last_rnd_q;
  assign bus.rnd_onehot  = rnd_onehot_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: default instance (4 cycles/round,
// decrypt enabled) and a 2 cycles/round instance with decrypt disabled.
// Outputs are packed as {start_ready, rnd_no, enb_ks, rnd_active, last_rnd,
// rnd_onehot, done} and compared against the expected cycle-by-cycle timing.
module tb_aes_round_ctrl;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int errors = 0;

  localparam logic [22:0] IDLE_VEC = {1'b1, 22'd0};

  aes_round_ctrl_if if1();
  aes_round_ctrl_if if2();

  aes_round_ctrl #(.CYC_PER_RND(4), .DEC_EN(1'b1)) u_dut1 (
    .clk(clk), .rstn(rstn), .bus(if1));
  aes_round_ctrl #(.CYC_PER_RND(2), .DEC_EN(1'b0)) u_dut2 (
    .clk(clk), .rstn(rstn), .bus(if2));

  always #5 clk = ~clk;

  logic [22:0] obs1, obs2;
  assign obs1 = {if1.start_ready, if1.rnd_no, if1.enb_ks, if1.rnd_active,
                 if1.last_rnd, if1.rnd_onehot, if1.done};
  assign obs2 = {if2.start_ready, if2.rnd_no, if2.enb_ks, if2.rnd_active,
                 if2.last_rnd, if2.rnd_onehot, if2.done};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [22:0] obs, input logic [22:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%06h expected=%06h", tag, obs, exp);
    end
  endtask

  // Expected outputs in cycle c after the handshake edge (c=1 is first RUN cycle).
  function automatic logic [22:0] exp_vec(input int c, input int nr, input bit dir, input int cpr);
    int p, ph;
    logic [13:0] oh;
    logic [3:0] rn;
    if (c <= nr * cpr) begin
      p  = (c - 1) / cpr + 1;
      ph = (c - 1) % cpr;
      oh = 14'd1 << (p - 1);
      rn = dir ? 4'(nr - p) : 4'(p);
      return {1'b0, rn, (ph == 0), 1'b1, (p == nr), oh, 1'b0};
    end
    return {1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 14'd0, 1'b1};
  endfunction

  task automatic run_block(input string tag, input bit sel, input int nr, input bit dir,
                           input int cpr, input int n);
    for (int c = 1; c <= n; c++) begin
      chk($sformatf("%s_c%0d", tag, c), sel ? obs2 : obs1, exp_vec(c, nr, dir, cpr));
      if (c < n) step();
    end
  endtask

  task automatic start1(input logic [1:0] kl, input logic dec);
    if1.key_len = kl;
    if1.decrypt = dec;
    if1.start_valid = 1'b1;
    step();
    if1.start_valid = 1'b0;
  endtask

  initial begin
    if1.start_valid = 1'b0; if1.key_len = 2'b00; if1.decrypt = 1'b0; if1.abort = 1'b0;
    if2.start_valid = 1'b0; if2.key_len = 2'b00; if2.decrypt = 1'b0; if2.abort = 1'b0;

    // Reset
    step(); step();
    chk("rst1", obs1, IDLE_VEC);
    chk("rst2", obs2, IDLE_VEC);
    rstn = 1'b1;
    step();
    chk("idle1", obs1, IDLE_VEC);

    // AES-128 encrypt: done at k+41
    start1(2'b00, 1'b0);
    run_block("e128", 1'b0, 10, 1'b0, 4, 41);
    step();
    chk("e128_after", obs1, IDLE_VEC);

    // AES-256 decrypt; inputs changed mid-run must be ignored
    start1(2'b10, 1'b1);
    if1.key_len = 2'b00;
    if1.decrypt = 1'b0;
    run_block("d256", 1'b0, 14, 1'b1, 4, 57);
    step();
    chk("d256_after", obs1, IDLE_VEC);

    // Back-to-back AES-192 with start_valid held high
    if1.key_len = 2'b01;
    if1.decrypt = 1'b0;
    if1.start_valid = 1'b1;
    step();
    run_block("b2b0", 1'b0, 12, 1'b0, 4, 49);
    step();
    run_block("b2b1", 1'b0, 12, 1'b0, 4, 49);
    if1.start_valid = 1'b0;
    step();
    chk("b2b_after", obs1, IDLE_VEC);

    // Abort at k+20
    start1(2'b00, 1'b0);
    run_block("ab20", 1'b0, 10, 1'b0, 4, 20);
    if1.abort = 1'b1;
    step();
    if1.abort = 1'b0;
    chk("ab20_idle", obs1, IDLE_VEC);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("ab20_hold%0d", i), obs1, IDLE_VEC);
    end

    // Abort on the final cycle: no done
    start1(2'b00, 1'b0);
    run_block("ab40", 1'b0, 10, 1'b0, 4, 40);
    if1.abort = 1'b1;
    step();
    if1.abort = 1'b0;
    chk("ab40_idle", obs1, IDLE_VEC);
    step();
    chk("ab40_hold", obs1, IDLE_VEC);

    // Abort in IDLE with simultaneous start: start accepted
    if1.abort = 1'b1;
    start1(2'b00, 1'b0);
    if1.abort = 1'b0;
    run_block("abidle", 1'b0, 10, 1'b0, 4, 41);
    step();
    chk("abidle_after", obs1, IDLE_VEC);

    // CYC_PER_RND=2, DEC_EN=0: decrypt ignored, key_len=11 -> 10 rounds
    if2.key_len = 2'b11;
    if2.decrypt = 1'b1;
    if2.start_valid = 1'b1;
    step();
    if2.start_valid = 1'b0;
    run_block("c2", 1'b1, 10, 1'b0, 2, 21);
    step();
    chk("c2_after", obs2, IDLE_VEC);

    // Reset during RUN at k+15, then a normal block
    start1(2'b00, 1'b0);
    run_block("rmid", 1'b0, 10, 1'b0, 4, 15);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("rmid_post", obs1, IDLE_VEC);
    start1(2'b00, 1'b0);
    run_block("rmid_new", 1'b0, 10, 1'b0, 4, 41);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
